// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and default geometry. A future serial_adder is expected to reuse this package.
package serial_subtractor_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake plus operand and result buses for the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  ready, busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// A single full-subtractor cell and a borrow flop replace a WIDTH-bit ripple chain.
// The result is published to a separate register on the last RUN edge so the
// partially filled shift register never reaches the outputs.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,  // >= 2
    parameter int CNT_W = DEF_CNT_W   // 2**CNT_W must exceed WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [WIDTH-2:0]   diff_sh;
    logic               borrow_q;
    logic               a_msb_q, b_msb_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q, ovf_q;

    logic               ready, accept, last;
    logic               d, borrow_nxt;
    logic [WIDTH-1:0]   diff_nxt;

    full_subtractor u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow_q),
        .d    (d),
        .bout (borrow_nxt)
    );

    assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept   = ready && bus.start;
    assign last     = (state_q == ST_RUN) && (count_q == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH bits the LSB-first stream is in place.
    assign diff_nxt = {d, diff_sh};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: DONE lasts one cycle and may chain straight into RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, serial datapath and result publication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            diff_sh  <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            borrow_q <= bus.bin;
            a_msb_q  <= bus.a[WIDTH-1];
            b_msb_q  <= bus.b[WIDTH-1];
            count_q  <= '0;
        end else if (state_q == ST_RUN) begin
            a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
            borrow_q <= borrow_nxt;
            diff_sh  <= diff_nxt[WIDTH-1:1];
            count_q  <= count_q + CNT_W'(1);
            if (last) begin
                diff_q <= diff_nxt;
                bout_q <= borrow_nxt;
                // d is the result sign bit on the last edge.
                ovf_q  <= (a_msb_q != b_msb_q) && (d != a_msb_q);
            end
        end
    end

    assign bus.ready = ready;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;
    assign bus.ovf   = ovf_q;

endmodule
